// File: rtl/v_cfg_unit_if.sv
// Config-issue and write-back handshake bundle between the scalar core and v_cfg_unit.
interface v_cfg_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            cfg_valid;
  logic            cfg_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output cfg_valid, instr, rs1_data, rs2_data, wb_ready,
    input  cfg_ready, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  cfg_valid, instr, rs1_data, rs2_data, wb_ready,
    output cfg_ready, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/v_cfg_unit.sv
// RVV configuration unit: executes vsetvli/vsetivli/vsetvl, holds vl/vtype and
// returns the new vl through a valid/ready write-back.
module v_cfg_unit #(
  parameter  int unsigned VLEN = 128,
  parameter  int unsigned ELEN = 32,
  parameter  int unsigned XLEN = 32,
  localparam int unsigned VLW  = $clog2(VLEN) + 1
) (
  input  logic            clk,
  input  logic            nrst,
  v_cfg_unit_if.slave     cfg,
  output logic [VLW-1:0]  vl,
  output logic [2:0]      vsew,
  output logic [2:0]      vlmul,
  output logic            vta,
  output logic            vma,
  output logic            vill
);

  localparam int unsigned LOG_VLEN = $clog2(VLEN);
  localparam int unsigned LOG_ELEN = $clog2(ELEN);
  localparam logic [6:0]  OPC_OPV  = 7'b1010111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0] state_q, state_d;
  logic       cfg_ready_q, cfg_ready_d;
  logic       wb_valid_q, wb_valid_d;
  logic       accept_c, commit_c;

  // Decode
  logic [4:0] rd_c, rs1_c;
  logic       is_vli_c, is_vil_c, is_vl_c, is_cfg_c;
  logic [7:0] vt_c;
  logic       rsv_c;

  always_comb begin
    rd_c     = cfg.instr[11:7];
    rs1_c    = cfg.instr[19:15];
    is_vli_c = ~cfg.instr[31];
    is_vil_c = (cfg.instr[31:30] == 2'b11);
    is_vl_c  = (cfg.instr[31:25] == 7'b1000000);
    is_cfg_c = (cfg.instr[6:0] == OPC_OPV) && (cfg.instr[14:12] == 3'b111) &&
               (is_vli_c || is_vil_c || is_vl_c);
    vt_c     = cfg.instr[27:20];
    rsv_c    = |cfg.instr[30:28];
    if (is_vl_c) begin
      vt_c  = cfg.rs2_data[7:0];
      // The vill position itself is also treated as reserved when written.
      rsv_c = |cfg.rs2_data[XLEN-1:8];
    end else if (is_vil_c) begin
      rsv_c = |cfg.instr[29:28];
    end
  end

  // Legality and VLMAX in the log domain, shifts only
  logic signed [7:0] sew_log_c, lmul_log_c, vlmax_log_c;
  logic [2:0]        vsew_c, vlmul_c;
  logic              ill_c;
  logic [VLW-1:0]    vlmax_c;
  logic [XLEN-1:0]   avl_c;

  always_comb begin
    vsew_c      = vt_c[5:3];
    vlmul_c     = vt_c[2:0];
    sew_log_c   = 8'sd3 + $signed({5'b0, vsew_c});
    lmul_log_c  = $signed({{5{vlmul_c[2]}}, vlmul_c});
    vlmax_log_c = $signed(8'(LOG_VLEN)) + lmul_log_c - sew_log_c;
    ill_c       = rsv_c || vsew_c[2] ||
                  (sew_log_c > $signed(8'(LOG_ELEN))) ||
                  (vlmul_c == 3'b100) ||
                  (vlmul_c[2] && (sew_log_c > $signed(8'(LOG_ELEN)) + lmul_log_c));
    vlmax_c     = ill_c ? '0 : (VLW'(1) << $unsigned(vlmax_log_c));

    if (is_vil_c)          avl_c = XLEN'(rs1_c);
    else if (rs1_c != '0)  avl_c = cfg.rs1_data;
    else if (rd_c != '0)   avl_c = XLEN'(vlmax_c);
    else                   avl_c = XLEN'(vl);
  end

  // FSM next state and registered handshake outputs
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg.cfg_valid && cfg_ready_q && is_cfg_c) begin
          accept_c = 1'b1;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        commit_c = 1'b1;
        state_d  = S_WB;
      end
      S_WB: begin
        if (cfg.wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cfg_ready_d = (state_d == S_IDLE);
    wb_valid_d  = (state_d == S_WB);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      cfg_ready_q <= 1'b1;
      wb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_ready_q <= cfg_ready_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

  // Decode results captured at the handshake, consumed in EXEC
  logic [7:0]      pend_vt_q;
  logic            pend_ill_q;
  logic [VLW-1:0]  pend_vlmax_q;
  logic [XLEN-1:0] pend_avl_q;
  logic [4:0]      pend_rd_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_vt_q    <= '0;
      pend_ill_q   <= 1'b0;
      pend_vlmax_q <= '0;
      pend_avl_q   <= '0;
      pend_rd_q    <= '0;
    end else if (accept_c) begin
      pend_vt_q    <= vt_c;
      pend_ill_q   <= ill_c;
      pend_vlmax_q <= vlmax_c;
      pend_avl_q   <= avl_c;
      pend_rd_q    <= rd_c;
    end
  end

  // Full-width compare so AVL above 2^VLW still saturates to VLMAX
  logic [VLW-1:0] new_vl_c;
  always_comb begin
    if (pend_ill_q)                          new_vl_c = '0;
    else if (pend_avl_q < XLEN'(pend_vlmax_q)) new_vl_c = VLW'(pend_avl_q);
    else                                     new_vl_c = pend_vlmax_q;
  end

  logic [VLW-1:0]  vl_q;
  logic [2:0]      vsew_q, vlmul_q;
  logic            vta_q, vma_q, vill_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vl_q      <= '0;
      vsew_q    <= '0;
      vlmul_q   <= '0;
      vta_q     <= 1'b0;
      vma_q     <= 1'b0;
      vill_q    <= 1'b1;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else if (commit_c) begin
      vl_q      <= new_vl_c;
      vsew_q    <= pend_ill_q ? 3'b000 : pend_vt_q[5:3];
      vlmul_q   <= pend_ill_q ? 3'b000 : pend_vt_q[2:0];
      vta_q     <= pend_ill_q ? 1'b0   : pend_vt_q[6];
      vma_q     <= pend_ill_q ? 1'b0   : pend_vt_q[7];
      vill_q    <= pend_ill_q;
      wb_rd_q   <= pend_rd_q;
      wb_data_q <= XLEN'(new_vl_c);
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign cfg.wb_valid  = wb_valid_q;
  assign cfg.wb_rd     = wb_rd_q;
  assign cfg.wb_data   = wb_data_q;
  assign vl            = vl_q;
  assign vsew          = vsew_q;
  assign vlmul         = vlmul_q;
  assign vta           = vta_q;
  assign vma           = vma_q;
  assign vill          = vill_q;

endmodule
